// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH runtime-programmable integer clock dividers on iclk.
//
// Each channel counts cnt = 0..d-1 and registers a divided clock (high while
// cnt < d/2) plus a one-cycle terminal-count tick. Downstream logic should use
// the ticks as clock enables on iclk rather than clocking from oclk.
//
// Ports:
//   iclk        master clock
//   ireset      asynchronous reset, active-high
//   ien         global run enable (0 freezes counters and clocks, ticks drop)
//   iclr        synchronous restart of every channel
//   iwr_en      divisor write strobe
//   iwr_ch      target channel of the write
//   iwr_div     new divisor (0 is rejected)
//   oclk        registered divided clocks, one per channel
//   otick       one-cycle pulse on the last cycle of each period
//   opending    a written divisor is waiting for the next period boundary
//   ohalf_tick  pulse on the first low cycle of oclk (only with CLKDIV_HALF_TICK_EN)
//
// Optional feature macro: CLKDIV_HALF_TICK_EN adds ohalf_tick.
module clk_div_bank #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ien,
    input  logic              iclr,
    input  logic              iwr_en,
    input  logic [CH_W-1:0]   iwr_ch,
    input  logic [CNT_W-1:0]  iwr_div,
    output logic [NUM_CH-1:0] oclk,
    output logic [NUM_CH-1:0] otick,
`ifdef CLKDIV_HALF_TICK_EN
    output logic [NUM_CH-1:0] opending,
    output logic [NUM_CH-1:0] ohalf_tick
`else
    output logic [NUM_CH-1:0] opending
`endif
);

    logic wr_ok;

    // A write only lands on an existing channel with a usable divisor.
    assign wr_ok = iwr_en && (32'(iwr_ch) < 32'(NUM_CH)) && (iwr_div != '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt, d, pend_div;
        logic             wr, wrap, clk_q, tick_q, pend_q;

        assign wr   = wr_ok && (iwr_ch == CH_W'(i));
        assign wrap = cnt == d - 1'b1;

        // The divisor only changes when cnt restarts at 0, so cnt can never
        // exceed a shrunk divisor.
        always_ff @(posedge iclk or posedge ireset) begin
            if (ireset) begin
                cnt      <= '0;
                d        <= CNT_W'(DIV_DEFAULT);
                pend_div <= '0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else if (iclr) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pend_q <= 1'b0;
                d      <= wr ? iwr_div : pend_q ? pend_div : d;
            end else begin
                if (ien) begin
                    tick_q <= wrap;
                    clk_q  <= cnt < (d >> 1);
                    cnt    <= wrap ? '0 : cnt + 1'b1;
                    if (wrap && pend_q) begin
                        d      <= pend_div;
                        pend_q <= 1'b0;
                    end
                end else begin
                    tick_q <= 1'b0;
                end
                // Placed last so a write on the wrap edge stays pending for
                // the next period while the wrap consumes the older value.
                if (wr) begin
                    pend_div <= iwr_div;
                    pend_q   <= 1'b1;
                end
            end
        end

        assign oclk[i]     = clk_q;
        assign otick[i]    = tick_q;
        assign opending[i] = pend_q;

`ifdef CLKDIV_HALF_TICK_EN
        logic half_q;

        // cnt == d/2 is the first count with oclk low; d=1 has no high phase.
        always_ff @(posedge iclk or posedge ireset) begin
            if (ireset)
                half_q <= 1'b0;
            else if (iclr)
                half_q <= 1'b0;
            else
                half_q <= ien && (d > CNT_W'(1)) && (cnt == (d >> 1));
        end

        assign ohalf_tick[i] = half_q;
`endif
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed self-checking bench for clk_div_bank.
module tb_clk_div_bank;

    logic       iclk = 1'b0;
    logic       ireset, ien, iclr, iwr_en;
    logic [1:0] iwr_ch;
    logic [7:0] iwr_div;
    logic [2:0] oclk, otick, opending;
`ifdef CLKDIV_HALF_TICK_EN
    logic [2:0] ohalf_tick;
`endif

    int n_chk = 0;
    int n_err = 0;

    clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DIV_DEFAULT(4)) dut (
        .iclk(iclk),
        .ireset(ireset),
        .ien(ien),
        .iclr(iclr),
        .iwr_en(iwr_en),
        .iwr_ch(iwr_ch),
        .iwr_div(iwr_div),
        .oclk(oclk),
        .otick(otick),
`ifdef CLKDIV_HALF_TICK_EN
        .opending(opending),
        .ohalf_tick(ohalf_tick)
`else
        .opending(opending)
`endif
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] dv);
        iwr_en  = 1'b1;
        iwr_ch  = ch;
        iwr_div = dv;
    endtask

    task automatic wr_off();
        iwr_en  = 1'b0;
        iwr_ch  = '0;
        iwr_div = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ireset = 1'b1;
        ien    = 1'b0;
        iclr   = 1'b0;
        wr_off();
        #12;
        chk("rst_clk", 32'(oclk), 32'h0);
        chk("rst_tick", 32'(otick), 32'h0);
        chk("rst_pend", 32'(opending), 32'h0);
        ireset = 1'b0;
        ien    = 1'b1;

        // default d=4 on every channel: oclk 1,1,0,0 and tick on the 4th cycle
        for (int i = 0; i < 16; i++) begin
            step();
            chk("def_clk", 32'(oclk), (i % 4 < 2) ? 32'h7 : 32'h0);
            chk("def_tick", 32'(otick), (i % 4 == 3) ? 32'h7 : 32'h0);
            chk("def_pend", 32'(opending), 32'h0);
`ifdef CLKDIV_HALF_TICK_EN
            chk("def_half", 32'(ohalf_tick), (i % 4 == 2) ? 32'h7 : 32'h0);
`endif
        end

        // ch1 <- 5, applied at the next wrap (3 edges later)
        wr(2'd1, 8'd5);
        step();
        wr_off();
        chk("odd_pend0", 32'(opending), 32'h2);
        step();
        step();
        chk("odd_pend2", 32'(opending), 32'h2);
        step();
        chk("odd_pend3", 32'(opending), 32'h0);
        chk("odd_lasttick", 32'(otick[1]), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("odd_clk1", 32'(oclk[1]), 32'(i % 5 < 2));
            chk("odd_tick1", 32'(otick[1]), 32'(i % 5 == 4));
            chk("odd_clk0", 32'(oclk[0]), 32'(i % 4 < 2));
        end

        // ch0 <- 2 written while cnt=1: pending for the remaining 2 edges
        step();
        step();
        step();
        wr(2'd0, 8'd2);
        step();
        wr_off();
        chk("bnd_pend_a", 32'(opending[0]), 32'h1);
        step();
        chk("bnd_pend_b", 32'(opending[0]), 32'h1);
        step();
        chk("bnd_pend_c", 32'(opending[0]), 32'h0);
        chk("bnd_wrap", 32'(otick[0]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("d2_clk", 32'(oclk[0]), 32'(i % 2 == 0));
            chk("d2_tick", 32'(otick[0]), 32'(i % 2 == 1));
        end

        // pending 3, then write 4 exactly on the wrap edge: 3 applies now, 4 one period later
        wr(2'd0, 8'd3);
        step();
        wr(2'd0, 8'd4);
        step();
        wr_off();
        chk("wrap_pend", 32'(opending[0]), 32'h1);
        chk("wrap_tick", 32'(otick[0]), 32'h1);
        step();
        chk("d3_clk_a", 32'(oclk[0]), 32'h1);
        chk("d3_tick_a", 32'(otick[0]), 32'h0);
        step();
        chk("d3_clk_b", 32'(oclk[0]), 32'h0);
        chk("d3_pend_b", 32'(opending[0]), 32'h1);
        step();
        chk("d3_tick_c", 32'(otick[0]), 32'h1);
        chk("d3_pend_c", 32'(opending[0]), 32'h0);

        // rejected writes: divisor 0 and channel 3 (out of range)
        wr(2'd0, 8'd0);
        step();
        chk("rej_div0", 32'(opending), 32'h0);
        wr(2'd3, 8'd5);
        step();
        wr_off();
        chk("rej_ch", 32'(opending), 32'h0);
        step();
        chk("rej_clk", 32'(oclk[0]), 32'h0);
        step();
        chk("rej_tick", 32'(otick[0]), 32'h1);

        // overwrite: 7 then 3 before the wrap, 3 wins
        wr(2'd0, 8'd7);
        step();
        wr(2'd0, 8'd3);
        step();
        wr_off();
        chk("ovr_pend", 32'(opending[0]), 32'h1);
        step();
        step();
        chk("ovr_applied", 32'(opending[0]), 32'h0);
        chk("ovr_wtick", 32'(otick[0]), 32'h1);
        step();
        chk("ovr_clk", 32'(oclk[0]), 32'h1);
        step();
        chk("ovr_tick_a", 32'(otick[0]), 32'h0);
        step();
        chk("ovr_tick_b", 32'(otick[0]), 32'h1);
        step();
        step();
        step();
        chk("ovr_tick_c", 32'(otick[0]), 32'h1);

        // freeze for 10 edges; write during freeze stays pending
        step();
        step();
        chk("pre_frz_clk", 32'(oclk), 32'h6);
        ien = 1'b0;
        wr(2'd0, 8'd4);
        for (int i = 0; i < 10; i++) begin
            step();
            wr_off();
            chk("frz_clk", 32'(oclk), 32'h6);
            chk("frz_tick", 32'(otick), 32'h0);
            chk("frz_pend", 32'(opending), 32'h1);
`ifdef CLKDIV_HALF_TICK_EN
            chk("frz_half", 32'(ohalf_tick), 32'h0);
`endif
        end

        // clear with a concurrent write: ch0 restarts with d=6
        ien  = 1'b1;
        iclr = 1'b1;
        wr(2'd0, 8'd6);
        step();
        iclr = 1'b0;
        wr_off();
        chk("clr_clk", 32'(oclk), 32'h0);
        chk("clr_tick", 32'(otick), 32'h0);
        chk("clr_pend", 32'(opending), 32'h0);
        begin
            logic [2:0] exp_clk [6] = '{3'b111, 3'b111, 3'b001, 3'b000, 3'b100, 3'b110};
            logic [2:0] exp_tck [6] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001};
            for (int i = 0; i < 6; i++) begin
                step();
                chk("aclr_clk", 32'(oclk), 32'(exp_clk[i]));
                chk("aclr_tick", 32'(otick), 32'(exp_tck[i]));
            end
        end

        // async reset mid-period (ch1 d=5 at cnt=3), between clock edges
        step();
        step();
        chk("pre_rst_clk", 32'(oclk), 32'h1);
        chk("pre_rst_tick", 32'(otick), 32'h4);
        #2;
        ireset = 1'b1;
        #1;
        chk("arst_clk", 32'(oclk), 32'h0);
        chk("arst_tick", 32'(otick), 32'h0);
        chk("arst_pend", 32'(opending), 32'h0);
        ireset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_clk", 32'(oclk), (i % 4 < 2) ? 32'h7 : 32'h0);
            chk("post_tick", 32'(otick), (i % 4 == 3) ? 32'h7 : 32'h0);
`ifdef CLKDIV_HALF_TICK_EN
            chk("post_half", 32'(ohalf_tick), (i % 4 == 2) ? 32'h7 : 32'h0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised successor to the fixed 100 MHz to 25 MHz pixel-clock divider.
- Provides NUM_CH independent integer dividers from one master clock. Each channel has a runtime-programmable divisor, a registered divided clock (about 50% duty) and a one-cycle terminal-count tick.
- Feeds the VGA timing, mouse/PS2 sampling and calculator display logic. Downstream logic uses the ticks as clock enables on iclk.
- Divisor changes apply glitch-free at period boundaries.

Parameters:
- NUM_CH, 2, number of divider channels (1..8).
- CNT_W, 8, counter/divisor width in bits.
- DIV_DEFAULT, 4, divisor loaded into every channel at reset (4 gives 25 MHz from 100 MHz).

Ports:
- iclk  in  1  master clock (100 MHz).
- ireset  in  1  asynchronous reset, active-high.
- ien  in  1  global run enable; 0 freezes all channels.
- iclr  in  1  synchronous restart of all channels.
- iwr_en  in  1  divisor write strobe.
- iwr_ch  in  $clog2(NUM_CH) (min 1)  target channel of write.
- iwr_div  in  CNT_W  new divisor value.
- oclk  out  NUM_CH  divided clocks, registered.
- otick  out  NUM_CH  one-cycle pulse per period, registered.
- opending  out  NUM_CH  divisor write accepted but not yet applied.

Behaviour:
- Clock and reset: one clock, iclk, all state on its rising edge. ireset is asynchronous and active-high.
- Reset state, per channel:
  - cnt=0, d=DIV_DEFAULT, pend_div=0.
  - oclk=0, otick=0, opending=0.
- Priority: ireset > iclr > normal operation.
- Normal operation, on a rising edge with ien=1, per channel:
  - otick <= (cnt==d-1).
  - oclk <= (cnt < d>>1).
  - cnt <= (cnt==d-1) ? 0 : cnt+1.
- Resulting latency: outputs lag cnt by one cycle. For d=4 after reset: oclk sequence 1,1,0,0 repeating; otick is high during the 4th cycle, i.e. the last low cycle of oclk.
- Divisor d=1: otick high every enabled cycle; oclk stays 0.
- Odd divisor d: oclk high for floor(d/2) cycles, low for ceil(d/2) cycles.
- ien=0: cnt and oclk hold; otick forced 0 on the next edge; writes are still accepted.
- Write acceptance:
  - A write is accepted when iwr_en=1, iwr_ch<NUM_CH and iwr_div!=0.
  - Accepted write: pend_div[ch] <= iwr_div, opending[ch] <= 1.
  - Rejected writes (channel out of range, or divisor 0) change nothing.
- Pending overwrite: a second accepted write while pending replaces pend_div (last write wins).
- Apply point: on the enabled edge where cnt==d-1 and opending=1, the channel does d <= pend_div, opending <= 0, cnt <= 0. The new period starts on the following cycle.
- Write coincident with wrap edge: the current wrap applies the old pending value (if any). The new write becomes pending and applies at the next wrap.
- Write while d is large and ien=0: stays pending indefinitely until a wrap or iclr.
- iclr=1 (independent of ien), all channels:
  - cnt <= 0, oclk <= 0, otick <= 0.
  - d <= iwr_div if an accepted write targets that channel this cycle; else pend_div if opending; else d unchanged.
  - opending <= 0.
- Divisor shrink: a new d smaller than the old cnt is safe only because apply happens at wrap (cnt=0). There is no out-of-range count state.
- Reset mid-period: all outputs drop asynchronously and the divisor returns to DIV_DEFAULT.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CLKDIV_HALF_TICK_EN.
- Defined:
  - Adds output ohalf_tick (out, NUM_CH).
  - Reset 0. On an enabled edge: ohalf_tick <= (d>=2) && (cnt == d>>1). Cleared by iclr and held 0 when ien=0.
  - It pulses during the first low cycle of oclk, marking the falling edge as an enable.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Default run: reset, ien=1, 16 cycles → both oclk 1,1,0,0 repeating; otick high in cycles 4, 8, 12, 16; opending=0.
- Odd divisor: write ch1 div=5, run until applied → oclk[1] 1,1,0,0,0 repeating; otick[1] every 5th cycle; ch0 undisturbed.
- Boundary apply: write ch0 div=2 at cnt=1 of a d=4 period → opending[0]=1 for exactly the remaining cycles. Also write on the wrap edge itself → applied one full old period later.
- Rejects/overwrite: write div=0 and iwr_ch=NUM_CH → no state change. Two writes 7 then 3 before wrap → d=3 applied.
- Freeze/clear: ien=0 for 10 cycles → oclk holds, otick 0. iclr with a concurrent write div=6 to ch0 → next cycles oclk[0] 1,1,1,0,0,0.
- Async reset mid-period (d=5, cnt=3), no clock edge → outputs 0 immediately; after release, period is 4 again. With CLKDIV_HALF_TICK_EN: ohalf_tick in cycle 3 of each d=4 period.
